// File: rtl/lm80c_kbd_pkg.sv
// Shared types, scancode constants and the PS/2 set-2 to LM80C matrix key map.
package lm80c_kbd_pkg;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] row;
      logic [2:0] col;
   } key_pos_t;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;
   localparam logic [7:0] SC_BAT = 8'hAA;

   // ext selects the E0-prefixed half of the table; a miss returns valid=0.
   function automatic key_pos_t keymap(input logic ext, input logic [7:0] code);
      key_pos_t k;
      k = '0;
      case ({ext, code})
         9'h05A:  k = {1'b1, 3'd0, 3'd7};  // Enter
         9'h171:  k = {1'b1, 3'd0, 3'd0};  // Del
         9'h029:  k = {1'b1, 3'd1, 3'd0};  // Space
         9'h016:  k = {1'b1, 3'd1, 3'd1};  // 1
         9'h01E:  k = {1'b1, 3'd1, 3'd2};  // 2
         9'h01C:  k = {1'b1, 3'd2, 3'd1};  // A
         9'h01B:  k = {1'b1, 3'd2, 3'd3};  // S
         9'h023:  k = {1'b1, 3'd2, 3'd4};  // D
         9'h015:  k = {1'b1, 3'd3, 3'd1};  // Q
         9'h01D:  k = {1'b1, 3'd3, 3'd2};  // W
         9'h175:  k = {1'b1, 3'd6, 3'd3};  // Up
         9'h172:  k = {1'b1, 3'd6, 3'd4};  // Down
         9'h012:  k = {1'b1, 3'd7, 3'd0};  // LShift
         9'h014:  k = {1'b1, 3'd7, 3'd2};  // Ctrl
         9'h011:  k = {1'b1, 3'd7, 3'd3};  // Alt
         default: k = '0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/lm80c_ps2_keymatrix_ps2_rx.sv
// PS/2 line receiver: 2-FF synchronisers, clock glitch filter, frame FSM and timeout.
//   state    | meaning
//   RX_IDLE  | waiting for a start bit (data=0 on a tick)
//   RX_SHIFT | collecting 8 data bits, parity, stop (bitcnt 0..9)
module ps2_rx
   import lm80c_kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 86000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       scan_valid,
   output logic [7:0] scan_code,
   output logic       parity_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          flt_q, flt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          tick;
   rx_state_t     state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_q, to_d;
   logic          valid_q, valid_d, perr_q, perr_d;
   logic [7:0]    code_q, code_d;

   // Filter: the clock flips only after FILTER_LEN consecutive differing samples.
   always_comb begin
      flt_d  = flt_q;
      fcnt_d = fcnt_q;
      tick   = 1'b0;
      if (clk_s2_q == flt_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
         flt_d  = clk_s2_q;
         fcnt_d = '0;
         tick   = flt_q;
      end else begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      to_d     = to_q;
      code_d   = code_q;
      valid_d  = 1'b0;
      perr_d   = 1'b0;
      if (tick) begin
         to_d = TW'(TIMEOUT_CYCLES - 1);
         case (state_q)
            RX_IDLE: begin
               if (!dat_s2_q) begin
                  state_d  = RX_SHIFT;
                  bitcnt_d = '0;
               end
            end
            RX_SHIFT: begin
               if (bitcnt_q < 4'd8) begin
                  shreg_d  = {dat_s2_q, shreg_q[7:1]};
                  bitcnt_d = bitcnt_q + 1'b1;
               end else if (bitcnt_q == 4'd8) begin
                  par_d    = dat_s2_q;
                  bitcnt_d = bitcnt_q + 1'b1;
               end else begin
                  state_d = RX_IDLE;
                  if ((^{shreg_q, par_q}) && dat_s2_q) begin
                     valid_d = 1'b1;
                     code_d  = shreg_q;
                  end else begin
                     perr_d = 1'b1;
                  end
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end else if (state_q == RX_SHIFT) begin
         if (to_q == '0) state_d = RX_IDLE;
         else            to_d    = to_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         flt_q    <= 1'b1;
         fcnt_q   <= '0;
         state_q  <= RX_IDLE;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         to_q     <= '0;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         code_q   <= '0;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
         flt_q    <= flt_d;
         fcnt_q   <= fcnt_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         to_q     <= to_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         code_q   <= code_d;
      end
   end

   assign scan_valid = valid_q;
   assign scan_code  = code_q;
   assign parity_err = perr_q;

endmodule

// File: rtl/lm80c_ps2_keymatrix.sv
// PS/2 keyboard to LM80C 8x8 active-low key matrix: receiver, E0/F0 decoder, matrix store.
// Optional Ctrl+Alt+Del reset request enabled by defining LM80C_KBD_RESETKEY_EN.
module lm80c_ps2_keymatrix
   import lm80c_kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 86000
) (
   input  logic            sys_clock,
   input  logic            RESET,
   input  logic            ps2_clk,
   input  logic            ps2_data,
   output logic [7:0][7:0] KM,
   output logic            scan_valid,
   output logic [7:0]      scan_code,
   output logic            parity_err,
   output logic            reset_req
);

   logic [7:0][7:0] km_q, km_d;
   logic            ext_q, ext_d, brk_q, brk_d;
   key_pos_t        hit;
   logic            all_up;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (sys_clock),
      .rst        (RESET),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .scan_valid (scan_valid),
      .scan_code  (scan_code),
      .parity_err (parity_err)
   );

   // BAT-complete, keyboard error and overrun codes all mean "assume every key is up".
   assign all_up = (scan_code == SC_BAT) || (scan_code == 8'hFC) ||
                   (scan_code == 8'h00) || (scan_code == 8'hFF);

   always_comb begin
      km_d  = km_q;
      ext_d = ext_q;
      brk_d = brk_q;
      hit   = keymap(ext_q, scan_code);
      if (scan_valid) begin
         if (scan_code == SC_EXT) begin
            ext_d = 1'b1;
         end else if (scan_code == SC_BRK) begin
            brk_d = 1'b1;
         end else begin
            if (all_up)         km_d = '1;
            else if (hit.valid) km_d[hit.row][hit.col] = brk_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end else if (parity_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (RESET) begin
         km_q  <= '1;
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else begin
         km_q  <= km_d;
         ext_q <= ext_d;
         brk_q <= brk_d;
      end
   end

   assign KM = km_q;

`ifdef LM80C_KBD_RESETKEY_EN
   logic ctrl_q, ctrl_d, alt_q, alt_d, del_q, del_d, rreq_q;

   always_comb begin
      ctrl_d = ctrl_q;
      alt_d  = alt_q;
      del_d  = del_q;
      if (scan_valid && scan_code != SC_EXT && scan_code != SC_BRK) begin
         if (all_up) begin
            ctrl_d = 1'b0;
            alt_d  = 1'b0;
            del_d  = 1'b0;
         end else if (!ext_q && scan_code == 8'h14) begin
            ctrl_d = !brk_q;
         end else if (!ext_q && scan_code == 8'h11) begin
            alt_d = !brk_q;
         end else if (ext_q && scan_code == 8'h71) begin
            del_d = !brk_q;
         end
      end
   end

   always_ff @(posedge sys_clock) begin
      if (RESET) begin
         ctrl_q <= 1'b0;
         alt_q  <= 1'b0;
         del_q  <= 1'b0;
         rreq_q <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         alt_q  <= alt_d;
         del_q  <= del_d;
         rreq_q <= ctrl_q & alt_q & del_q;
      end
   end

   assign reset_req = rreq_q;
`else
   assign reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_lm80c_ps2_keymatrix.sv
// Directed bench for lm80c_ps2_keymatrix: bit-banged PS/2 frames against a hand-kept key matrix.
module tb_lm80c_ps2_keymatrix;

   localparam int TO_CYC = 3000;

   logic            sys_clock = 1'b0;
   logic            RESET     = 1'b1;
   logic            ps2_clk   = 1'b1;
   logic            ps2_data  = 1'b1;
   logic [7:0][7:0] KM;
   logic            scan_valid, parity_err, reset_req;
   logic [7:0]      scan_code;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_valid = 0;
   int          n_perr  = 0;
   int          exp_valid = 0;
   int          exp_perr  = 0;
   logic [63:0] exp_km = '1;
   logic        exp_rreq;

   lm80c_ps2_keymatrix #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .sys_clock  (sys_clock),
      .RESET      (RESET),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .KM         (KM),
      .scan_valid (scan_valid),
      .scan_code  (scan_code),
      .parity_err (parity_err),
      .reset_req  (reset_req)
   );

   always #5 sys_clock = ~sys_clock;

   // Strobe cycle counters: one count per cycle high, so a stretched pulse shows up.
   always @(negedge sys_clock) begin
      if (scan_valid) n_valid++;
      if (parity_err) n_perr++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sys_clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_cyc(20);
      if (bad_par) exp_perr++;
      else         exp_valid++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0);
   endtask

   task automatic set_key(input int r, input int c, input logic v);
      exp_km[r*8 + c] = v;
   endtask

   initial begin
`ifdef LM80C_KBD_RESETKEY_EN
      exp_rreq = 1'b1;
`else
      exp_rreq = 1'b0;
`endif
      wait_cyc(3);
      check("rst_km", KM, exp_km);
      check("rst_valid", {63'd0, scan_valid}, 64'd0);
      check("rst_code", {56'd0, scan_code}, 64'd0);
      check("rst_perr", {63'd0, parity_err}, 64'd0);
      check("rst_rreq", {63'd0, reset_req}, 64'd0);
      RESET = 1'b0;
      wait_cyc(5);

      // Press A
      send_byte(8'h1C);
      set_key(2, 1, 1'b0);
      check("a_valid_cnt", 64'(n_valid), 64'(exp_valid));
      check("a_code", {56'd0, scan_code}, 64'h1C);
      check("a_row2", {56'd0, KM[2]}, 64'hFD);
      check("a_km", KM, exp_km);

      // Release A, then press again to prove brk was cleared
      send_byte(8'hF0);
      send_byte(8'h1C);
      set_key(2, 1, 1'b1);
      check("a_rel_km", KM, exp_km);
      send_byte(8'h1C);
      set_key(2, 1, 1'b0);
      check("a_repress_km", KM, exp_km);
      send_byte(8'h1C);
      check("a_typematic_km", KM, exp_km);
      send_byte(8'hF0);
      send_byte(8'h1C);
      set_key(2, 1, 1'b1);
      check("a_rel2_km", KM, exp_km);

      // Extended Up, then bare 75 is unmapped
      send_byte(8'hE0);
      send_byte(8'h75);
      set_key(6, 3, 1'b0);
      check("up_row6", {56'd0, KM[6]}, 64'hF7);
      check("up_km", KM, exp_km);
      send_byte(8'h75);
      check("bare75_km", KM, exp_km);
      check("bare75_code", {56'd0, scan_code}, 64'h75);

      // Bad parity leaves KM alone and normal decoding resumes
      send_byte(8'h1C);
      set_key(2, 1, 1'b0);
      send_frame(8'h1C, 1'b1);
      check("perr_cnt", 64'(n_perr), 64'(exp_perr));
      check("perr_valid_cnt", 64'(n_valid), 64'(exp_valid));
      check("perr_km", KM, exp_km);
      send_byte(8'hF0);
      send_byte(8'h1C);
      set_key(2, 1, 1'b1);
      check("perr_brk_km", KM, exp_km);
      // parity error between F0 and the code drops the break prefix
      send_byte(8'hF0);
      send_frame(8'h33, 1'b1);
      send_byte(8'h1C);
      set_key(2, 1, 1'b0);
      check("perr_clr_brk_km", KM, exp_km);
      check("perr_cnt2", 64'(n_perr), 64'(exp_perr));

      // Shift + Enter, then BAT releases everything
      send_byte(8'h12);
      send_byte(8'h5A);
      set_key(7, 0, 1'b0);
      set_key(0, 7, 1'b0);
      check("sh_row7", {56'd0, KM[7]}, 64'hFE);
      check("ent_row0", {56'd0, KM[0]}, 64'h7F);
      check("multi_km", KM, exp_km);
      send_byte(8'hAA);
      exp_km = '1;
      check("bat_km", KM, exp_km);

      // Partial frame abandoned by timeout; the next frame decodes cleanly
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_cyc(TO_CYC + 500);
      check("to_no_strobe", 64'(n_valid + n_perr), 64'(exp_valid + exp_perr));
      send_byte(8'h5A);
      set_key(0, 7, 1'b0);
      check("to_row0", {56'd0, KM[0]}, 64'h7F);
      check("to_km", KM, exp_km);

      // Ctrl + Alt + Del
      send_byte(8'h14);
      send_byte(8'h11);
      check("rreq_two_keys", {63'd0, reset_req}, 64'd0);
      send_byte(8'hE0);
      send_byte(8'h71);
      check("rreq_set", {63'd0, reset_req}, {63'd0, exp_rreq});
      send_byte(8'hF0);
      send_byte(8'h11);
      check("rreq_clr", {63'd0, reset_req}, 64'd0);

      // RESET in the middle of a frame
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      @(negedge sys_clock);
      RESET = 1'b1;
      @(posedge sys_clock);
      #1;
      exp_km = '1;
      check("midrst_km", KM, exp_km);
      RESET = 1'b0;
      wait_cyc(5);
      send_byte(8'h1C);
      set_key(2, 1, 1'b0);
      check("postrst_km", KM, exp_km);
      check("final_valid_cnt", 64'(n_valid), 64'(exp_valid));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lm80c_ps2_keymatrix.md
Name: lm80c_ps2_keymatrix

Overview:
- Converts a PS/2 keyboard stream into the 8x8 active-low key matrix KM[7:0][7:0] consumed by the PSG-port keyboard scanner.
- Three stages: PS/2 line receiver (framing, parity, timeout), scancode decoder FSM (E0/F0 prefixes), and a registered matrix store.
- A matrix bit is 0 while its key is held and 1 when released.

Parameters:
- FILTER_LEN, 8: sys_clock cycles ps2_clk must stay stable before an edge is accepted.
- TIMEOUT_CYCLES, 86000: idle cycles mid-frame before the frame is aborted (about 2 ms at 42.95 MHz).

Ports:
- sys_clock  in  1  system clock
- RESET  in  1  reset; synchronous, active-high
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- KM  out  [7:0] x8 (KM[7:0])  key matrix, row-indexed, 0 = pressed
- scan_valid  out  1  one-cycle strobe, good byte received
- scan_code  out  8  last good byte
- parity_err  out  1  one-cycle strobe, bad parity or bad stop bit
- reset_req  out  1  three-key reset request (see Optional Feature)

Behaviour:
- Reset values: KM all 8'hFF; scan_valid, parity_err, reset_req = 0; scan_code = 0; both FSMs IDLE; prefix flags cleared.
- Input conditioning:
  - ps2_clk and ps2_data each pass a 2-FF synchroniser.
  - The filtered clock changes state only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock is a "tick"; data is sampled on the tick.
- Receiver FSM: IDLE -> SHIFT -> IDLE.
  - IDLE: a tick with data=0 (start bit) enters SHIFT with bitcnt=0. A tick with data=1 is ignored.
  - SHIFT: bitcnt 0-7 shift data LSB-first, bitcnt 8 samples parity, bitcnt 9 samples stop.
  - After the stop tick: if odd parity over data+parity holds and stop=1, assert scan_valid and load scan_code on the next cycle (cycle N). Otherwise assert parity_err at cycle N. Either way, return to IDLE.
  - The timeout counter clears on every tick. If it reaches TIMEOUT_CYCLES while in SHIFT, return to IDLE and discard the partial byte; no strobe.
- Decoder, acting at cycle N on scan_valid:
  - 0xE0: ext <= 1.
  - 0xF0: brk <= 1.
  - 0xAA, 0xFC, 0x00 or 0xFF: KM <= all 8'hFF; clear ext and brk.
  - Any other code: look up {ext, code} in the key map.
    - On a hit: KM[row][col] <= brk (1 = release, 0 = press).
    - On a miss: no change.
    - Clear ext and brk in both cases.
  - The KM update is visible at cycle N+1.
- A parity_err clears ext and brk and leaves KM unchanged.
- Repeated make codes (typematic) rewrite 0 and are idempotent.
- Unmapped keys never alter KM.
- RESET asserted mid-frame discards the frame and releases all keys on the next clock edge.
- Simultaneous events: RESET wins over everything. Timeout and tick in the same cycle: the tick wins and clears the timeout counter.

Optional Feature:
- Macro: LM80C_KBD_RESETKEY_EN.
- Defined: a separate held-state tracks Ctrl (0x14), Alt (0x11) and Del (E0 71), each also cleared by its break code. reset_req = 1 in every cycle all three are held, one cycle after the last make code's KM update.
- Undefined: reset_req is tied to 0 and the tracking logic is absent.
- The reset_req port exists in both builds.

Decomposition:
- Package lm80c_kbd_pkg holds:
  - typedef key_pos_t {valid, row[2:0], col[2:0]}
  - constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_BAT=8'hAA
  - function keymap(ext, code) returning key_pos_t
- Fixed keymap entries include:
  - 0x1C 'A' -> row 2, col 1
  - 0x5A Enter -> row 0, col 7
  - 0x12 LShift -> row 7, col 0
  - E0 0x75 Up -> row 6, col 3
- Sub-module ps2_rx: synchroniser, filter, receiver FSM and timeout. It outputs scan_valid, scan_code and parity_err.
- The top level holds the decoder and matrix.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> scan_valid once, scan_code=8'h1C, KM[2]=8'hFD at N+1, all other rows 8'hFF.
- Bytes F0 then 1C after the press above -> KM[2]=8'hFF; ext and brk are clear afterwards.
- Bytes E0 75 -> KM[6]=8'hF7. Then byte 75 alone (not mapped without E0) -> KM unchanged.
- Frame 0x1C with parity bit 1 -> parity_err one cycle, no scan_valid, KM unchanged. Then bytes F0 1C -> treated as a normal break.
- Press 0x12 and 0x5A, then send 8'hAA -> KM all 8'hFF. Separately: 5 bits then 90000 idle cycles, then a valid 0x5A frame -> KM[0]=8'h7F.
- With LM80C_KBD_RESETKEY_EN defined: bytes 14, 11, E0 71 -> reset_req=1. Then F0 11 -> reset_req=0. Without the macro, reset_req stays 0.
